sa_stream_fifo: RTL and testbench

Parametrised circular-buffer FIFO that feeds one row or column of operands into the systolic array. It is the successor to the fixed 32x16 shift-pipe input FIFO, with these additions:
- Independent WRITE and READ strobes, with simultaneous push and pop in one cycle.
- Configurable width, depth and thresholds.
- Registered output with a valid strobe, plus an occupancy count.
- Synchronous flush and sticky overflow/underflow error flags.
One instance sits per array lane, between the host loader and the array edge.

---
 rtl/sa_stream_fifo.sv | 99 +++++++++
 tb/tb_sa_stream_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sa_stream_fifo.sv
// Circular-buffer operand FIFO for one systolic-array lane: registered pop output,
// occupancy-decoded status flags and sticky overflow/underflow error flags.
module sa_stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AF_TH = 12,
  parameter int AE_TH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       FLUSH,
  input  logic                       WRITE,
  input  logic [WIDTH-1:0]           DATA_IN,
  input  logic                       READ,
  output logic [WIDTH-1:0]           DATA_OUT,
  output logic                       OUT_VALID,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       FULL,
  output logic                       EMPTY,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY,
  output logic                       OVERFLOW,
  output logic                       UNDERFLOW,
  input  logic                       CLR_ERR
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             pop_ok, push_ok, ovf_evt, udf_evt;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop_ok  = READ && (count != '0);
    push_ok = WRITE && ((count != CW'(DEPTH)) || pop_ok);
    ovf_evt = !FLUSH && WRITE && !push_ok;
    udf_evt = !FLUSH && READ && (count == '0);
  end

  always_ff @(posedge CLK) begin
    if (!FLUSH && push_ok)
      mem[wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DATA_OUT  <= '0;
      OUT_VALID <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      DATA_OUT  <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= pop_ok;
      if (pop_ok) begin
        DATA_OUT <= mem[rd_ptr];
        rd_ptr   <= ptr_next(rd_ptr);
      end
      if (push_ok)
        wr_ptr <= ptr_next(wr_ptr);
      if (push_ok && !pop_ok)
        count <= count + CW'(1);
      else if (pop_ok && !push_ok)
        count <= count - CW'(1);
    end
  end

  // A new error event in the same cycle as CLR_ERR keeps its flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= ovf_evt || (OVERFLOW && !CLR_ERR);
      UNDERFLOW <= udf_evt || (UNDERFLOW && !CLR_ERR);
    end
  end

  always_comb begin
    COUNT        = count;
    FULL         = (count == CW'(DEPTH));
    EMPTY        = (count == '0);
    ALMOST_FULL  = (count >= CW'(AF_TH));
    ALMOST_EMPTY = (count <= CW'(AE_TH));
  end

endmodule

// File: tb/tb_sa_stream_fifo.sv
// Self-checking bench for sa_stream_fifo: queue-based reference model compared every
// cycle, plus directed literal checks for each scenario.
module tb_sa_stream_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AF_TH = 12;
  localparam int AE_TH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             CLK, RST_N, FLUSH, WRITE, READ, CLR_ERR;
  logic [WIDTH-1:0] DATA_IN, DATA_OUT;
  logic             OUT_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
  logic [CW-1:0]    COUNT;

  sa_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_TH(AF_TH), .AE_TH(AE_TH)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .WRITE(WRITE), .DATA_IN(DATA_IN),
    .READ(READ), .DATA_OUT(DATA_OUT), .OUT_VALID(OUT_VALID), .COUNT(COUNT),
    .FULL(FULL), .EMPTY(EMPTY), .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .CLR_ERR(CLR_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model
  logic [WIDTH-1:0] q [$];
  logic [WIDTH-1:0] m_dout;
  bit               m_valid, m_ovf, m_udf;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic model_update(input bit w, input logic [WIDTH-1:0] d, input bit r,
                              input bit f, input bit c);
    bit pop, push, ovf_e, udf_e;
    ovf_e = 1'b0;
    udf_e = 1'b0;
    if (f) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
    end else begin
      pop   = r && (q.size() != 0);
      push  = w && ((q.size() < DEPTH) || pop);
      udf_e = r && (q.size() == 0);
      ovf_e = w && !push;
      m_valid = pop;
      if (pop) m_dout = q.pop_front();
      if (push) q.push_back(d);
    end
    m_ovf = ovf_e || (m_ovf && !c);
    m_udf = udf_e || (m_udf && !c);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("count",     32'(COUNT),        32'(q.size()));
      chk("full",      32'(FULL),         32'(q.size() == DEPTH));
      chk("empty",     32'(EMPTY),        32'(q.size() == 0));
      chk("afull",     32'(ALMOST_FULL),  32'(q.size() >= AF_TH));
      chk("aempty",    32'(ALMOST_EMPTY), 32'(q.size() <= AE_TH));
      chk("out_valid", 32'(OUT_VALID),    32'(m_valid));
      chk("data_out",  DATA_OUT,          m_dout);
      chk("overflow",  32'(OVERFLOW),     32'(m_ovf));
      chk("underflow", 32'(UNDERFLOW),    32'(m_udf));
    end
  end

  // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
  task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit f, input bit c);
    WRITE = w; DATA_IN = d; READ = r; FLUSH = f; CLR_ERR = c;
    @(posedge CLK);
    if (RST_N) model_update(w, d, r, f, c);
    @(negedge CLK);
    WRITE = 1'b0; READ = 1'b0; FLUSH = 1'b0; CLR_ERR = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_w;
    RST_N = 1'b0; FLUSH = 1'b0; WRITE = 1'b0; READ = 1'b0; CLR_ERR = 1'b0; DATA_IN = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST_N  = 1'b1;
    chk_en = 1'b1;
    chk("rst_empty",  32'(EMPTY),        32'd1);
    chk("rst_aempty", 32'(ALMOST_EMPTY), 32'd1);
    chk("rst_full",   32'(FULL),         32'd0);
    chk("rst_afull",  32'(ALMOST_FULL),  32'd0);

    // 1: fill with 0x11..0x20, then drain in order
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("t1_af_below", 32'(ALMOST_FULL), 32'd0);
      if (i == 11) chk("t1_af_at12",  32'(ALMOST_FULL), 32'd1);
    end
    chk("t1_full",  32'(FULL),  32'd1);
    chk("t1_count", 32'(COUNT), 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t1_dout",  DATA_OUT,        32'h11 + 32'(i));
      chk("t1_valid", 32'(OUT_VALID),  32'd1);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("t1_valid_end", 32'(OUT_VALID), 32'd0);
    chk("t1_empty_end", 32'(EMPTY),     32'd1);

    // 2: full, simultaneous push/pop across the pointer wrap
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h11 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
      exp_w = (i < 16) ? 32'h11 + 32'(i) : 32'h100 + 32'(i - 16);
      chk("t2_count", 32'(COUNT), 32'd16);
      chk("t2_dout",  DATA_OUT,   exp_w);
    end
    chk("t2_ovf", 32'(OVERFLOW), 32'd0);

    // 3: dropped push when full, then clear, then drain
    cyc(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf",   32'(OVERFLOW), 32'd1);
    chk("t3_count", 32'(COUNT),    32'd16);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(OVERFLOW), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t3_no_dead", 32'(DATA_OUT == 32'hDEAD), 32'd0);
      chk("t3_dout",    DATA_OUT,                  32'h104 + 32'(i));
    end

    // 4: push+pop on empty, no fall-through
    cyc(1'b1, 32'hCAFE, 1'b1, 1'b0, 1'b0);
    chk("t4_udf",   32'(UNDERFLOW), 32'd1);
    chk("t4_count", 32'(COUNT),     32'd1);
    chk("t4_valid", 32'(OUT_VALID), 32'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t4_dout",   DATA_OUT,       32'hCAFE);
    chk("t4_valid2", 32'(OUT_VALID), 32'd1);
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t4_set_wins", 32'(UNDERFLOW), 32'd1);

    // 5: flush beats write and read, leaves error flags alone
    for (int i = 0; i < 7; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'hBEEF, 1'b1, 1'b1, 1'b0);
    chk("t5_count", 32'(COUNT),     32'd0);
    chk("t5_empty", 32'(EMPTY),     32'd1);
    chk("t5_valid", 32'(OUT_VALID), 32'd0);
    chk("t5_dout",  DATA_OUT,       32'd0);
    chk("t5_udf",   32'(UNDERFLOW), 32'd1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_udf_clr", 32'(UNDERFLOW), 32'd0);

    // 6: asynchronous reset mid-cycle
    for (int i = 0; i < 9; i++) cyc(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    chk("t6_count_pre", 32'(COUNT), 32'd9);
    #2;
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("t6_count", 32'(COUNT),     32'd0);
    chk("t6_empty", 32'(EMPTY),     32'd1);
    chk("t6_dout",  DATA_OUT,       32'd0);
    chk("t6_valid", 32'(OUT_VALID), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_udf",   32'(UNDERFLOW), 32'd1);
    chk("t6_novld", 32'(OUT_VALID), 32'd0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
